// File: rtl/acc_display_driver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : acc_display_driver_pkg
//  Description : Shared constants, glyph table and FSM encoding for the
//                accumulator display driver and its BCD converter.
//  Revision    : 1.0 - initial release
// ============================================================================
package acc_display_driver_pkg;

  localparam int c_num_digits  = 5;
  localparam int c_num_pos     = 6;
  localparam int c_conv_cycles = 16;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] c_seg_0     = 7'h40;
  localparam logic [6:0] c_seg_1     = 7'h79;
  localparam logic [6:0] c_seg_2     = 7'h24;
  localparam logic [6:0] c_seg_3     = 7'h30;
  localparam logic [6:0] c_seg_4     = 7'h19;
  localparam logic [6:0] c_seg_5     = 7'h12;
  localparam logic [6:0] c_seg_6     = 7'h02;
  localparam logic [6:0] c_seg_7     = 7'h78;
  localparam logic [6:0] c_seg_8     = 7'h00;
  localparam logic [6:0] c_seg_9     = 7'h10;
  localparam logic [6:0] c_seg_blank = 7'h7F;
  localparam logic [6:0] c_seg_minus = 7'h3F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_LATCH = 2'd2
  } disp_state_t;

  // Map one BCD digit to its glyph; non-decimal nibbles show blank
  function automatic logic [6:0] seg_glyph(input logic [3:0] digit);
    logic [6:0] glyph;
    case (digit)
      4'd0:    glyph = c_seg_0;
      4'd1:    glyph = c_seg_1;
      4'd2:    glyph = c_seg_2;
      4'd3:    glyph = c_seg_3;
      4'd4:    glyph = c_seg_4;
      4'd5:    glyph = c_seg_5;
      4'd6:    glyph = c_seg_6;
      4'd7:    glyph = c_seg_7;
      4'd8:    glyph = c_seg_8;
      4'd9:    glyph = c_seg_9;
      default: glyph = c_seg_blank;
    endcase
    return glyph;
  endfunction

endpackage
`default_nettype wire

// File: rtl/acc_display_driver_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : acc_display_driver_bin2bcd_seq
//  Description : Iterative double-dabble converter, one shift per clock.
//                17-bit magnitude in, five BCD digits out.
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_display_driver_bin2bcd_seq
  import acc_display_driver_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [16:0] i_mag,
  output logic        o_done,
  output logic [19:0] o_bcd
);

  // {bcd[19:0], mag[15:0]} shift register. The magnitude MSB is preloaded
  // straight into the BCD LSB: that is exactly what the first of 17 shifts
  // would do (an all-zero BCD needs no add-3), so 16 clocks cover 17 bits.
  logic [35:0] r_sr;
  logic [3:0]  r_cnt;
  logic        r_run;
  logic [19:0] w_adj;

  // Add-3 correction on every BCD nibble that is 5 or more
  for (genvar gi = 0; gi < c_num_digits; gi++) begin : g_adj
    assign w_adj[4*gi +: 4] = (r_sr[16 + 4*gi +: 4] >= 4'd5) ?
                              (r_sr[16 + 4*gi +: 4] + 4'd3) :
                               r_sr[16 + 4*gi +: 4];
  end

  // Load on start, then correct-and-shift for the fixed iteration count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr  <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_sr  <= {19'd0, i_mag[16], i_mag[15:0]};
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_sr  <= {w_adj, r_sr[15:0]} << 1;
      r_cnt <= r_cnt + 4'd1;
      if (r_cnt == 4'(c_conv_cycles - 1)) begin
        r_run <= 1'b0;
      end
    end
  end

  // done marks the cycle whose edge performs the final shift
  assign o_done = r_run && (r_cnt == 4'(c_conv_cycles - 1));
  assign o_bcd  = r_sr[35:16];

endmodule
`default_nettype wire

// File: rtl/acc_display_driver.sv
`default_nettype none
// ============================================================================
//  Module      : acc_display_driver
//  Description : Accepts a 16-bit result, converts it to decimal and drives
//                a multiplexed sign + 5-digit active-low 7-segment display.
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_display_driver
  import acc_display_driver_pkg::*;
#(
  parameter int REFRESH_DIV   = 50000,
  parameter int BLANK_LEADING = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] val_in,
  input  logic        signed_mode,
  input  logic        load,
  output logic        busy,
  output logic        ready,
  output logic [6:0]  seg,
  output logic [5:0]  an
);

  localparam int c_refresh_w = $clog2(REFRESH_DIV);

  disp_state_t                   r_state;
  disp_state_t                   w_state_nxt;
  logic                          w_accept;
  logic                          w_neg;
  logic [16:0]                   w_mag;
  logic                          r_neg_pend;
  logic                          w_conv_done;
  logic [19:0]                   w_bcd;
  logic [4*c_num_digits-1:0]     r_digits;
  logic                          r_neg;
  logic                          r_ready;
  logic [c_refresh_w-1:0]        r_refresh;
  logic [2:0]                    r_scan;
  logic [4:1]                    w_blank;
  logic [5:0]                    w_an_nxt;
  logic [6:0]                    w_seg_nxt;
  logic [3:0]                    w_nib;
  logic                          w_nib_blank;
  logic [5:0]                    r_an;
  logic [6:0]                    r_seg;

  assign w_accept = (r_state == ST_IDLE) && load;
  assign w_neg    = signed_mode & val_in[15];
  // Negating the sign-extended value keeps 16'h8000 representable (32768)
  assign w_mag    = w_neg ? (17'd0 - {1'b1, val_in}) : {1'b0, val_in};

  acc_display_driver_bin2bcd_seq u_bin2bcd_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_accept),
    .i_mag   (w_mag),
    .o_done  (w_conv_done),
    .o_bcd   (w_bcd)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: accept in IDLE, wait for converter, one LATCH cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (load) w_state_nxt = ST_CONV;
      ST_CONV:  if (w_conv_done) w_state_nxt = ST_LATCH;
      ST_LATCH: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign busy  = (r_state != ST_IDLE);
  assign ready = r_ready;

  // Hold the sign of the accepted value until its conversion is latched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_pend <= 1'b0;
    end else if (w_accept) begin
      r_neg_pend <= w_neg;
    end
  end

  // Display registers change only in LATCH; READY pulses alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits <= '0;
      r_neg    <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      r_ready <= (r_state == ST_LATCH);
      if (r_state == ST_LATCH) begin
        r_digits <= w_bcd;
        r_neg    <= r_neg_pend;
      end
    end
  end

  // Refresh divider and position scan
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refresh <= '0;
      r_scan    <= '0;
    end else if (r_refresh == c_refresh_w'(REFRESH_DIV - 1)) begin
      r_refresh <= '0;
      r_scan    <= (r_scan == 3'(c_num_pos - 1)) ? 3'd0 : r_scan + 3'd1;
    end else begin
      r_refresh <= r_refresh + 1'b1;
    end
  end

  // Digit i is a leading zero when it and every higher digit are zero
  for (genvar gi = 1; gi < c_num_digits; gi++) begin : g_blank
    assign w_blank[gi] = (BLANK_LEADING != 0) &&
                         (r_digits[4*c_num_digits-1:4*gi] == '0);
  end

  // Select position enable and glyph for the current scan index
  always_comb begin
    w_an_nxt    = 6'h3F;
    w_seg_nxt   = c_seg_blank;
    w_nib       = 4'd0;
    w_nib_blank = 1'b1;
    case (r_scan)
      3'd0: begin w_an_nxt = 6'b111110; w_nib = r_digits[3:0];   w_nib_blank = 1'b0;       end
      3'd1: begin w_an_nxt = 6'b111101; w_nib = r_digits[7:4];   w_nib_blank = w_blank[1]; end
      3'd2: begin w_an_nxt = 6'b111011; w_nib = r_digits[11:8];  w_nib_blank = w_blank[2]; end
      3'd3: begin w_an_nxt = 6'b110111; w_nib = r_digits[15:12]; w_nib_blank = w_blank[3]; end
      3'd4: begin w_an_nxt = 6'b101111; w_nib = r_digits[19:16]; w_nib_blank = w_blank[4]; end
      3'd5: begin w_an_nxt = 6'b011111; end
      default: ;
    endcase
    if (r_scan == 3'd5) begin
      w_seg_nxt = r_neg ? c_seg_minus : c_seg_blank;
    end else if (!w_nib_blank) begin
      w_seg_nxt = seg_glyph(w_nib);
    end
  end

  // Registered display outputs, all positions off during reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= 6'h3F;
      r_seg <= c_seg_blank;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule
`default_nettype wire
